inst_axi_rd_bridge: RTL

//  Responder side of the fetch stage's SRAM-like instruction request interface
//  (inst_req/inst_addr/inst_addr_ok). Each accepted request becomes one

---
 rtl/inst_axi_rd_bridge_if.sv | 47 ++++
 rtl/inst_axi_rd_bridge.sv | 113 +++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge_if.sv
// Fetch-side SRAM-like request port plus the AXI4 AR/R channels of inst_axi_rd_bridge.
// Defining INST_BRIDGE_ERR_EN adds the inst_err response flag.
interface inst_axi_rd_bridge_if;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic [31:0] inst_rdata;
   logic        inst_data_ok;
`ifdef INST_BRIDGE_ERR_EN
   logic        inst_err;
`endif
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   // Bridge side: answers fetch requests, masters the AXI read channels.
   modport slave (
      input  inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
      output inst_addr_ok, inst_rdata, inst_data_ok,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
`ifdef INST_BRIDGE_ERR_EN
      , output inst_err
`endif
   );

   modport master (
      output inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
      input  inst_addr_ok, inst_rdata, inst_data_ok,
             arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready
`ifdef INST_BRIDGE_ERR_EN
      , input inst_err
`endif
   );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// Fetch request to single-beat AXI4 read bridge, up to MAX_OUTSTANDING reads in flight, in-order data.
// Optional INST_BRIDGE_ERR_EN: registered inst_err flag from rresp[1].
module inst_axi_rd_bridge #(
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter logic [3:0]  ARID_VAL        = 4'd0
) (
   input  logic                 clk,
   input  logic                 resetn,
   inst_axi_rd_bridge_if.slave  bus
);
   localparam int unsigned    CW      = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_OUTSTANDING);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_ADDR = 1'b1} ar_state_t;

   ar_state_t     r_state;
   ar_state_t     w_state_nxt;
   logic [31:0]   r_araddr;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic [31:0]   r_rdata;
   logic          r_data_ok;
   logic          w_slot_free;
   logic          w_addr_ok;
   logic          w_unused_ok;

   // Full check uses the registered count, so a same-cycle retire does not reopen the gate.
   assign w_slot_free = (r_state == S_IDLE) || bus.arready;
   assign w_addr_ok   = bus.inst_req && w_slot_free && (r_cnt < CNT_MAX);

   assign bus.inst_addr_ok = w_addr_ok;
   assign bus.arvalid      = (r_state == S_ADDR);
   assign bus.araddr       = r_araddr;
   assign bus.arid         = ARID_VAL;
   assign bus.arlen        = 8'd0;
   assign bus.arsize       = 3'b010;
   assign bus.arburst      = 2'b01;
   assign bus.arlock       = 2'b00;
   assign bus.arcache      = 4'd0;
   assign bus.arprot       = 3'd0;
   assign bus.rready       = 1'b1;
   assign bus.inst_rdata   = r_rdata;
   assign bus.inst_data_ok = r_data_ok;

   // AR slot next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_addr_ok) w_state_nxt = S_ADDR;
            else           w_state_nxt = S_IDLE;
         end
         S_ADDR: begin
            if (bus.arready && !w_addr_ok) w_state_nxt = S_IDLE;
            else                           w_state_nxt = S_ADDR;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outstanding count; a stray beat at zero must not wrap the counter
   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_addr_ok, bus.rvalid})
         2'b10: w_cnt_nxt = r_cnt + CW'(1);
         2'b01: begin
            if (r_cnt != '0) w_cnt_nxt = r_cnt - CW'(1);
            else             w_cnt_nxt = r_cnt;
         end
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   // AR slot and counter registers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state  <= S_IDLE;
         r_araddr <= 32'd0;
         r_cnt    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_addr_ok) r_araddr <= bus.inst_addr;
      end
   end

   // R path: one-cycle data_ok pulse, data held between beats
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_data_ok <= 1'b0;
         r_rdata   <= 32'd0;
      end else begin
         r_data_ok <= bus.rvalid;
         if (bus.rvalid) r_rdata <= bus.rdata;
      end
   end

`ifdef INST_BRIDGE_ERR_EN
   logic r_err;

   assign bus.inst_err = r_err;

   // SLVERR/DECERR flag travels with the data_ok pulse
   always_ff @(posedge clk) begin
      if (!resetn) r_err <= 1'b0;
      else         r_err <= bus.rvalid && bus.rresp[1];
   end

   assign w_unused_ok = ^{bus.rid, bus.rlast, bus.rresp[0]};
`else
   assign w_unused_ok = ^{bus.rid, bus.rlast, bus.rresp};
`endif
endmodule
